// File: rtl/ff_d.sv
// Parameterised D register with clock enable, asynchronous clear and asynchronous preset.
// Clear dominates preset; q comes straight from the storage element.
module ff_d #(
    parameter int                 WIDTH = 1,
    parameter logic [WIDTH-1:0]   INIT  = '0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             pre,
    input  logic             ce,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_d;
    // Power-up value; maps onto the flop INIT attribute on FPGA targets.
    logic [WIDTH-1:0] q_q = INIT;

    always_comb begin
        q_d = q_q;
        if (ce) begin
            q_d = d;
        end
    end

    always_ff @(posedge clk or posedge clr or posedge pre) begin
        if (clr) begin
            q_q <= '0;
        end else if (pre) begin
            q_q <= '1;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: tb/tb_ff_d.sv
// Directed, table-driven bench for ff_d (WIDTH=4, INIT=0); one line per transaction.
// The clock is driven by hand so asynchronous pulses can be placed anywhere in a cycle.
module tb_ff_d;

    localparam int WIDTH = 4;

    logic             clk;
    logic             clr;
    logic             pre;
    logic             ce;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;

    int checks;
    int failures;

    ff_d #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .clr (clr),
        .pre (pre),
        .ce  (ce),
        .d   (d),
        .q   (q)
    );

    typedef struct {
        logic             clr;
        logic             pre;
        logic             ce;
        logic [WIDTH-1:0] d;
        logic             do_edge;
        logic [WIDTH-1:0] exp_q;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [WIDTH-1:0] exp_q);
        checks++;
        if (q !== exp_q) begin
            failures++;
            $display("FAIL %s: q=%h expected=%h", name, q, exp_q);
        end else begin
            $display("ok   %s: q=%h", name, q);
        end
    endtask

    task automatic drive(input logic c, input logic p, input logic e, input logic [WIDTH-1:0] dd);
        clr = c;
        pre = p;
        ce  = e;
        d   = dd;
        #2;
    endtask

    task automatic rise();
        clk = 1'b1;
        #3;
    endtask

    task automatic fall();
        clk = 1'b0;
        #3;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        clk = 1'b0;
        clr = 1'b0;
        pre = 1'b0;
        ce  = 1'b0;
        d   = '0;

        //          clr   pre   ce    d      edge  exp
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 4'h0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 4'h0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 4'hF, 1'b1, 4'hF};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 4'h0, 1'b1, 4'h0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 4'hA, 1'b1, 4'hA};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 4'h5, 1'b1, 4'hA};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 4'hF, 1'b1, 4'hF};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 4'hF, 1'b0, 4'h0};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 4'hF, 1'b1, 4'h0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 4'hF, 1'b1, 4'h0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 4'h6, 1'b1, 4'h6};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 4'hF};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 4'h0, 1'b1, 4'hF};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 4'hF};
        vecs[14] = '{1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 4'h0};
        vecs[15] = '{1'b1, 1'b1, 1'b0, 4'hF, 1'b1, 4'h0};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0};

        #1;
        check("reset_init", 4'h0);

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].clr, vecs[i].pre, vecs[i].ce, vecs[i].d);
            if (vecs[i].do_edge) begin
                rise();
                check($sformatf("vec%0d_rise", i), vecs[i].exp_q);
                fall();
                check($sformatf("vec%0d_fall", i), vecs[i].exp_q);
            end else begin
                check($sformatf("vec%0d_async", i), vecs[i].exp_q);
                #3;
            end
        end

        // d toggles every half cycle with ce low: q must not move
        drive(1'b0, 1'b0, 1'b1, 4'h3);
        rise();
        fall();
        check("hold_load", 4'h3);
        ce = 1'b0;
        for (int c = 0; c < 4; c++) begin
            d = 4'hC;
            #2;
            rise();
            check($sformatf("hold_c%0d_hi", c), 4'h3);
            d = 4'h5;
            #2;
            fall();
            check($sformatf("hold_c%0d_lo", c), 4'h3);
        end
        drive(1'b0, 1'b0, 1'b1, 4'hC);
        rise();
        check("hold_capture", 4'hC);
        fall();

        // clr released in the same step as an enabled rising edge: d is captured
        drive(1'b1, 1'b0, 1'b1, 4'h9);
        check("coinc_clr_held", 4'h0);
        clr = 1'b0;
        clk = 1'b1;
        #3;
        check("coinc_clr_release", 4'h9);
        fall();

        // same for preset release
        drive(1'b0, 1'b1, 1'b1, 4'h2);
        check("coinc_pre_held", 4'hF);
        pre = 1'b0;
        clk = 1'b1;
        #3;
        check("coinc_pre_release", 4'h2);
        fall();

        // short clr pulse while clk is high, then low, with ce=1, d=F
        drive(1'b0, 1'b0, 1'b1, 4'hF);
        rise();
        check("pulse_preload", 4'hF);
        clr = 1'b1;
        #1;
        check("pulse_clk_high", 4'h0);
        clr = 1'b0;
        #1;
        check("pulse_released", 4'h0);
        fall();
        check("pulse_fall", 4'h0);
        rise();
        check("pulse_next_edge", 4'hF);
        fall();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
